// File: rtl/lens_remap_grid_interp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lens_remap_pkg
// Description : Shared geometry, widths, types and blend arithmetic for the
//               lens undistortion grid mapper.
// Revision    : 1.0 - initial release
// ============================================================================
package lens_remap_pkg;

  localparam int H_ACT      = 1280;
  localparam int V_ACT      = 720;
  localparam int XW         = 11;
  localparam int YW         = 10;
  localparam int GRID_SHIFT = 5;
  localparam int FRAC       = 4;
  localparam int CW         = 16;
  localparam int LAT        = 5;
  localparam int N_RD       = 4;

  // Grid nodes per row: one per pitch plus the closing right-hand node.
  function automatic int grid_w();
    return (H_ACT >> GRID_SHIFT) + 1;
  endfunction

  // Grid node rows: partial bottom cell rounded up, plus the closing row.
  function automatic int grid_h();
    return ((V_ACT + (1 << GRID_SHIFT) - 1) >> GRID_SHIFT) + 1;
  endfunction

  localparam int GW    = grid_w();
  localparam int GH    = grid_h();
  localparam int DEPTH = GW * GH;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = CW + GRID_SHIFT + 1;       // horizontal blend width
  localparam int VW    = CW + 2 * GRID_SHIFT + 2;   // vertical blend width
  localparam int RW    = VW - 2 * GRID_SHIFT;       // rounded result width

  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
  } coord_pair_t;

  // Per-pixel control carried alongside the arithmetic to the output stage.
  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          byp;
    logic          force_oob;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } out_ctl_t;

  function automatic logic [AW-1:0] node_addr(input int gx, input int gy);
    return AW'(gy * GW + gx);
  endfunction

  // a*(2^S-f) + b*f, exact in TW bits.
  function automatic logic signed [TW-1:0] hblend(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic [GRID_SHIFT-1:0] f);
    logic signed [TW-1:0] w0;
    logic signed [TW-1:0] w1;
    w1 = signed'(TW'(f));
    w0 = signed'(TW'(1 << GRID_SHIFT)) - w1;
    return TW'(a) * w0 + TW'(b) * w1;
  endfunction

  // t*(2^S-f) + bt*f, then round half-up and drop the 2S weight bits.
  function automatic logic signed [RW-1:0] vblend_round(input logic signed [TW-1:0] t,
                                                        input logic signed [TW-1:0] bt,
                                                        input logic [GRID_SHIFT-1:0] f);
    logic signed [VW-1:0] w0;
    logic signed [VW-1:0] w1;
    logic signed [VW-1:0] v;
    w1 = signed'(VW'(f));
    w0 = signed'(VW'(1 << GRID_SHIFT)) - w1;
    v  = VW'(t) * w0 + VW'(bt) * w1 + signed'(VW'(1 << (2 * GRID_SHIFT - 1)));
    return RW'(v >>> (2 * GRID_SHIFT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lens_remap_grid_interp_grid_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lens_grid_ram
// Description : Double-banked grid node store. Each bank is replicated once
//               per read port so all four cell corners are fetched in one
//               cycle; the single write port updates every replica.
// Revision    : 1.0 - initial release
// ============================================================================
module lens_grid_ram
  import lens_remap_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  coord_pair_t       wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_bank_i,
  input  logic [AW-1:0]     rd_addr_i [N_RD],
  output coord_pair_t       rd_data_o [N_RD]
);

  for (genvar r = 0; r < N_RD; r++) begin : g_rep
    coord_pair_t bank0_q [DEPTH];
    coord_pair_t bank1_q [DEPTH];
    coord_pair_t rd_q;

    // Broadcast write into this replica of the selected bank; registered read.
    always_ff @(posedge clk) begin
      if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
        if (wr_bank_i) bank1_q[wr_addr_i] <= wr_data_i;
        else           bank0_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
        rd_q <= rd_bank_i ? bank1_q[rd_addr_i[r]] : bank0_q[rd_addr_i[r]];
      end
    end

    assign rd_data_o[r] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/lens_remap_grid_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lens_remap_grid_interp
// Description : Maps display pixels to clamped fixed-point source coordinates
//               by bilinear interpolation of a double-buffered sparse grid.
//               Five-stage pipeline; bypass gives the identity mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module lens_remap_grid_interp
  import lens_remap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XW-1:0]     in_x,
  input  logic [YW-1:0]     in_y,
  input  logic              in_de,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              cfg_bypass,
  input  logic              cfg_wr_en,
  input  logic [AW-1:0]     cfg_wr_addr,
  input  logic [2*CW-1:0]   cfg_wr_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic [CW-1:0]     out_src_x,
  output logic [CW-1:0]     out_src_y,
  output logic              out_de,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_valid,
  output logic              out_oob
);

  localparam int S    = GRID_SHIFT;
  localparam int GXW  = XW - S;
  localparam int GYW  = YW - S;
  localparam int XMAX = (H_ACT - 1) << FRAC;
  localparam int YMAX = (V_ACT - 1) << FRAC;
  localparam int XLIM = H_ACT << FRAC;
  localparam int YLIM = V_ACT << FRAC;

  // ---------------- bank control ----------------
  logic active_q, busy_q, vs_prev_q;
  logic vs_rise, swap, rd_bank;

  assign vs_rise = in_vs & ~vs_prev_q;
  assign swap    = busy_q & vs_rise;
  // The read issued in the swap cycle already sees the new bank.
  assign rd_bank = swap ? ~active_q : active_q;

  // Commit arms a swap; the next vsync rising edge flips the active bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_prev_q <= in_vs;
      if (swap) begin
        active_q <= ~active_q;
        busy_q   <= 1'b0;
      end else if (!busy_q && cfg_commit) begin
        busy_q <= 1'b1;
      end
    end
  end

  // ---------------- stage 1: cell lookup ----------------
  logic [GXW-1:0] gx, gx1;
  logic [GYW-1:0] gy, gy1;
  logic           x_over, y_over;
  logic [AW-1:0]  rd_addr [N_RD];
  out_ctl_t       ctl_d;

  // Cell indices with saturation for off-screen pixels, corner addresses.
  always_comb begin
    x_over = int'(in_x) >= H_ACT;
    y_over = int'(in_y) >= V_ACT;
    gx     = x_over ? GXW'(GW - 2) : in_x[XW-1:S];
    gy     = y_over ? GYW'(GH - 2) : in_y[YW-1:S];
    gx1    = gx + GXW'(1);
    gy1    = (int'(gy) >= GH - 1) ? GYW'(GH - 1) : gy + GYW'(1);
    rd_addr[0] = node_addr(int'(gx),  int'(gy));
    rd_addr[1] = node_addr(int'(gx1), int'(gy));
    rd_addr[2] = node_addr(int'(gx),  int'(gy1));
    rd_addr[3] = node_addr(int'(gx1), int'(gy1));
    ctl_d.de        = in_de;
    ctl_d.hs        = in_hs;
    ctl_d.vs        = in_vs;
    ctl_d.byp       = cfg_bypass;
    ctl_d.force_oob = x_over | y_over;
    ctl_d.x         = in_x;
    ctl_d.y         = in_y;
  end

  coord_pair_t rd_data [N_RD];

  lens_grid_ram u_ram (
    .clk       (clk),
    .wr_en_i   (cfg_wr_en & ~busy_q),
    .wr_bank_i (~active_q),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_en_i   (in_de & ~cfg_bypass),
    .rd_bank_i (rd_bank),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // ---------------- stages 2..4 ----------------
  out_ctl_t              ctl1_q, ctl2_q, ctl3_q, ctl4_q;
  logic [S-1:0]          fx1_q, fy1_q, fx2_q, fy2_q, fy3_q;
  coord_pair_t           corner_q [N_RD];
  logic signed [TW-1:0]  tx_q, bx_q, ty_q, by_q;
  logic signed [RW-1:0]  rx_q, ry_q;

  // Control delay line; cleared on reset so in-flight pixels are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl1_q <= '0;
      ctl2_q <= '0;
      ctl3_q <= '0;
      ctl4_q <= '0;
    end else begin
      ctl1_q <= ctl_d;
      ctl2_q <= ctl1_q;
      ctl3_q <= ctl2_q;
      ctl4_q <= ctl3_q;
    end
  end

  // Datapath: corner capture, horizontal blend, vertical blend with rounding.
  always_ff @(posedge clk) begin
    fx1_q <= in_x[S-1:0];
    fy1_q <= in_y[S-1:0];
    fx2_q <= fx1_q;
    fy2_q <= fy1_q;
    fy3_q <= fy2_q;
    for (int i = 0; i < N_RD; i++) corner_q[i] <= rd_data[i];
    tx_q  <= hblend(corner_q[0].x, corner_q[1].x, fx2_q);
    bx_q  <= hblend(corner_q[2].x, corner_q[3].x, fx2_q);
    ty_q  <= hblend(corner_q[0].y, corner_q[1].y, fx2_q);
    by_q  <= hblend(corner_q[2].y, corner_q[3].y, fx2_q);
    rx_q  <= vblend_round(tx_q, bx_q, fy3_q);
    ry_q  <= vblend_round(ty_q, by_q, fy3_q);
  end

  // ---------------- stage 5: bounds, clamp, output ----------------
  int            ix, iy;
  logic [CW-1:0] src_x_d, src_y_d;
  logic          oob_d;

  // Out-of-bounds flag on the unclamped value, then clamp into the frame.
  always_comb begin
    ix      = int'(rx_q);
    iy      = int'(ry_q);
    oob_d   = ctl4_q.force_oob || (ix < 0) || (ix >= XLIM) || (iy < 0) || (iy >= YLIM);
    src_x_d = CW'((ix < 0) ? 0 : ((ix > XMAX) ? XMAX : ix));
    src_y_d = CW'((iy < 0) ? 0 : ((iy > YMAX) ? YMAX : iy));
    if (ctl4_q.byp) begin
      src_x_d = CW'({ctl4_q.x, {FRAC{1'b0}}});
      src_y_d = CW'({ctl4_q.y, {FRAC{1'b0}}});
      oob_d   = 1'b0;
    end
  end

  logic [CW-1:0] src_x_q, src_y_q;
  logic          oob_q, de_q, hs_q, vs_q;

  // Output registers; coordinates and flag only move on active pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_x_q <= '0;
      src_y_q <= '0;
      oob_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      de_q <= ctl4_q.de;
      hs_q <= ctl4_q.hs;
      vs_q <= ctl4_q.vs;
      if (ctl4_q.de) begin
        src_x_q <= src_x_d;
        src_y_q <= src_y_d;
        oob_q   <= oob_d;
      end
    end
  end

  assign cfg_busy  = busy_q;
  assign out_src_x = src_x_q;
  assign out_src_y = src_y_q;
  assign out_oob   = oob_q;
  assign out_de    = de_q;
  assign out_hs    = hs_q;
  assign out_vs    = vs_q;
  assign out_valid = de_q;

endmodule
`default_nettype wire

// File: tb/tb_lens_remap_grid_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lens_remap_grid_interp
// Description : Directed, table-driven bench for the lens grid mapper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lens_remap_grid_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] in_x;
  logic [9:0]  in_y;
  logic        in_de, in_hs, in_vs, cfg_bypass;
  logic        cfg_wr_en;
  logic [9:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic [15:0] out_src_x, out_src_y;
  logic        out_de, out_hs, out_vs, out_valid, out_oob;

  int total = 0;
  int bad   = 0;

  lens_remap_grid_interp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_de       (in_de),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .cfg_bypass  (cfg_bypass),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_commit  (cfg_commit),
    .cfg_busy    (cfg_busy),
    .out_src_x   (out_src_x),
    .out_src_y   (out_src_y),
    .out_de      (out_de),
    .out_hs      (out_hs),
    .out_vs      (out_vs),
    .out_valid   (out_valid),
    .out_oob     (out_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit byp;
    bit hs;
    bit vs;
    int ex;
    int ey;
    bit eoob;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Drive one pixel, confirm nothing appears after 4 edges and the result after 5.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    in_x = 11'(v.x); in_y = 10'(v.y); in_de = 1'b1;
    in_hs = v.hs; in_vs = v.vs; cfg_bypass = v.byp;
    @(negedge clk);
    in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; cfg_bypass = 1'b0;
    repeat (3) @(negedge clk);
    check({nm, ".early_valid"}, int'(out_valid), 0);
    @(negedge clk);
    check({nm, ".valid"}, int'(out_valid), 1);
    check({nm, ".src_x"}, int'(out_src_x), v.ex);
    check({nm, ".src_y"}, int'(out_src_y), v.ey);
    check({nm, ".oob"},   int'(out_oob),   int'(v.eoob));
    check({nm, ".hs"},    int'(out_hs),    int'(v.hs));
    check({nm, ".vs"},    int'(out_vs),    int'(v.vs));
  endtask

  // Fill the shadow bank with identity nodes, optionally with two extreme nodes.
  task automatic load_grid(input bit corrupt);
    int xs, ys;
    for (int gy = 0; gy < 24; gy++) begin
      for (int gx = 0; gx < 41; gx++) begin
        @(negedge clk);
        xs = gx * 512;
        ys = gy * 512;
        if (corrupt && gy == 0 && gx == 0) xs = -64;
        if (corrupt && gy == 0 && gx == 2) xs = 21000;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 10'(gy * 41 + gx);
        cfg_wr_data = {16'(xs), 16'(ys)};
      end
    end
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    @(negedge clk); cfg_commit = 1'b1;
    @(negedge clk); cfg_commit = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk); in_vs = 1'b1;
    @(negedge clk); in_vs = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // identity grid, interpolated
    tbl[0] = '{100,  50,  1'b0, 1'b1, 1'b0, 1600,  800,   1'b0};
    tbl[1] = '{0,    0,   1'b0, 1'b0, 1'b0, 0,     0,     1'b0};
    tbl[2] = '{16,   0,   1'b0, 1'b0, 1'b0, 256,   0,     1'b0};
    tbl[3] = '{16,   16,  1'b0, 1'b0, 1'b0, 256,   256,   1'b0};
    tbl[4] = '{1279, 719, 1'b0, 1'b1, 1'b0, 20464, 11504, 1'b0};
    tbl[5] = '{1300, 10,  1'b0, 1'b0, 1'b0, 20288, 160,   1'b1};
    tbl[6] = '{40,   720, 1'b0, 1'b0, 1'b0, 640,   11504, 1'b1};
    tbl[7] = '{1279, 719, 1'b1, 1'b0, 1'b0, 20464, 11504, 1'b0};
    tbl[8] = '{5,    3,   1'b1, 1'b1, 1'b0, 80,    48,    1'b0};

    rst_n = 1'b0; in_x = '0; in_y = '0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
    cfg_bypass = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_commit = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.valid", int'(out_valid), 0);
    check("reset.src_x", int'(out_src_x), 0);
    check("reset.src_y", int'(out_src_y), 0);
    check("reset.oob",   int'(out_oob),   0);
    check("reset.vs",    int'(out_vs),    0);
    check("reset.busy",  int'(cfg_busy),  0);
    rst_n = 1'b1;

    // Identity grid into bank 1, make it active.
    load_grid(1'b0);
    commit_pulse();
    check("init.busy_set", int'(cfg_busy), 1);
    vs_pulse();
    check("init.busy_clr", int'(cfg_busy), 0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Extreme grid into bank 0 while bank 1 stays in use.
    load_grid(1'b1);
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}, "pre_commit");
    commit_pulse();
    check("commit.busy", int'(cfg_busy), 1);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_addr = 10'd0; cfg_wr_data = {16'd5000, 16'd0};
    @(negedge clk);
    cfg_wr_en = 1'b0;
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}, "busy_old_bank");
    check("busy.still", int'(cfg_busy), 1);
    // Pixel coincident with the vsync rise already reads the new bank.
    run_vec('{64, 0, 1'b0, 1'b0, 1'b1, 20464, 0, 1'b1}, "swap_edge_hi");
    check("swap.busy_clr", int'(cfg_busy), 0);
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1}, "new_bank_lo");
    run_vec('{0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0}, "bypass_lo");
    run_vec('{64, 0, 1'b1, 1'b0, 1'b0, 1024, 0, 1'b0}, "bypass_hi");

    // Commit on the same cycle as a vsync rise waits for the next frame.
    @(negedge clk); cfg_commit = 1'b1; in_vs = 1'b1;
    @(negedge clk); cfg_commit = 1'b0; in_vs = 1'b0;
    check("coinc.busy", int'(cfg_busy), 1);
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1}, "coinc_no_swap");
    vs_pulse();
    check("coinc.busy_clr", int'(cfg_busy), 0);
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}, "coinc_swapped");

    // Reset in the middle of a stream of active pixels.
    @(negedge clk);
    in_x = 11'd100; in_y = 10'd50; in_de = 1'b1;
    repeat (5) @(negedge clk);
    check("stream.valid", int'(out_valid), 1);
    check("stream.src_x", int'(out_src_x), 1600);
    rst_n = 1'b0; in_de = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.valid", int'(out_valid), 0);
    check("midrst.src_x", int'(out_src_x), 0);
    check("midrst.src_y", int'(out_src_y), 0);
    check("midrst.oob",   int'(out_oob),   0);
    check("midrst.busy",  int'(cfg_busy),  0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("midrst.stale%0d", k), int'(out_valid), 0);
    end
    run_vec('{100, 50, 1'b0, 1'b0, 1'b0, 1600, 800, 1'b0}, "after_rst");
    run_vec('{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1}, "after_rst_bank0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
